// File: rtl/music_pkg.sv
// music_pkg: shared note, state and tempo definitions for the music sequencer
package music_pkg;
    localparam int NOTE_W = 6;
    localparam logic [NOTE_W-1:0] NOTE_REST = '0;
    typedef enum logic [2:0] {IDLE, PRIME, PLAY, PAUSE, DONE} state_t;
    localparam logic [1:0] TEMPO_NORM    = 2'd0;
    localparam logic [1:0] TEMPO_HALF    = 2'd1;
    localparam logic [1:0] TEMPO_QUARTER = 2'd2;
    localparam logic [1:0] TEMPO_DOUBLE  = 2'd3;
    function automatic logic [NOTE_W-1:0] song_note(input int unsigned idx);
        return NOTE_W'(idx + 1);
    endfunction
endpackage

// File: rtl/music_sequencer_song_rom.sv
// song_rom: synchronous song ROM, one-cycle read latency, rests beyond the song end
module song_rom
    import music_pkg::*;
#(
    parameter int SONG_LEN = 64,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [NOTE_W-1:0] data
);
    // registered read; addresses past the song return a rest
    always_ff @(posedge clk)
        data <= (32'(addr) < 32'(SONG_LEN)) ? song_note(32'(addr)) : NOTE_REST;
endmodule

// File: rtl/music_sequencer.sv
// music_sequencer: steps a ROM song at a selectable tempo into a 4-note scrolling window
module music_sequencer
    import music_pkg::*;
#(
    parameter int SONG_LEN    = 64,
    parameter int ADDR_W      = 6,
    parameter int BEAT_CYCLES = 25_000_000
) (
    input  logic              EGO1_Clock,
    input  logic              reset,
    input  logic              btn_play,
    input  logic              btn_restart,
    input  logic [1:0]        tempo_sel,
    input  logic              loop_en,
    output logic [NOTE_W-1:0] track0,
    output logic [NOTE_W-1:0] track1,
    output logic [NOTE_W-1:0] track2,
    output logic [NOTE_W-1:0] track3,
    output logic [ADDR_W-1:0] note_pos,
    output logic              playing,
    output logic              song_done,
    output logic              beat_pulse
);
    localparam int CNT_W = $clog2(2 * BEAT_CYCLES);
    localparam logic [ADDR_W-1:0] POS_MAX  = '1;
    localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(SONG_LEN - 1);
    localparam logic [ADDR_W-1:0] PRIME_END = ADDR_W'(4);

    state_t            state;
    logic              auto_play;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  beat_last;
    logic [CNT_W-1:0]  tempo_last;
    logic [ADDR_W-1:0] fetch_addr;
    logic [NOTE_W-1:0] prefetch;
    logic              tick;

    song_rom #(.SONG_LEN(SONG_LEN), .ADDR_W(ADDR_W)) u_rom (
        .clk  (EGO1_Clock),
        .addr (fetch_addr),
        .data (prefetch)
    );

    function automatic logic [ADDR_W-1:0] inc_sat(input logic [ADDR_W-1:0] x);
        return (x == POS_MAX) ? x : x + 1'b1;
    endfunction

    // last count of a beat for the requested tempo
    always_comb
        tempo_last = (tempo_sel == TEMPO_HALF)    ? CNT_W'(BEAT_CYCLES / 2 - 1) :
                     (tempo_sel == TEMPO_QUARTER) ? CNT_W'(BEAT_CYCLES / 4 - 1) :
                     (tempo_sel == TEMPO_DOUBLE)  ? CNT_W'(2 * BEAT_CYCLES - 1) :
                                                    CNT_W'(BEAT_CYCLES - 1);

    // a beat ends only while playing undisturbed by a button
    always_comb
        tick = (state == PLAY) && !btn_play && !btn_restart && (cnt == beat_last);

    assign playing   = (state == PLAY);
    assign song_done = (state == DONE);

    // sequencer FSM, beat counter, window shift register and fetch pointer
    always_ff @(posedge EGO1_Clock) begin
        if (reset) begin
            state      <= IDLE;
            auto_play  <= 1'b0;
            cnt        <= '0;
            beat_last  <= CNT_W'(BEAT_CYCLES - 1);
            fetch_addr <= '0;
            note_pos   <= '0;
            {track0, track1, track2, track3} <= '0;
            beat_pulse <= 1'b0;
        end else begin
            beat_pulse <= tick;
            case (state)
                IDLE: if (btn_play) begin
                    state      <= PRIME;
                    auto_play  <= 1'b1;
                    fetch_addr <= '0;
                end
                PRIME: begin
                    if (fetch_addr != '0)
                        {track0, track1, track2, track3} <= {track1, track2, track3, prefetch};
                    if (fetch_addr == PRIME_END) begin
                        state     <= auto_play ? PLAY : PAUSE;
                        note_pos  <= '0;
                        cnt       <= '0;
                        beat_last <= tempo_last;
                    end else begin
                        fetch_addr <= fetch_addr + 1'b1;
                    end
                end
                PLAY: if (btn_restart) begin
                    state      <= PRIME;
                    auto_play  <= 1'b1;
                    cnt        <= '0;
                    fetch_addr <= '0;
                end else if (btn_play) begin
                    state <= PAUSE;
                end else if (tick) begin
                    cnt       <= '0;
                    beat_last <= tempo_last;
                    if (note_pos == LAST_POS) begin
                        if (loop_en) begin
                            state      <= PRIME;
                            auto_play  <= 1'b1;
                            fetch_addr <= '0;
                        end else begin
                            state <= DONE;
                            {track0, track1, track2, track3} <= '0;
                        end
                    end else begin
                        {track0, track1, track2, track3} <= {track1, track2, track3, prefetch};
                        note_pos   <= inc_sat(note_pos);
                        fetch_addr <= inc_sat(fetch_addr);
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                PAUSE: if (btn_restart) begin
                    state      <= PRIME;
                    auto_play  <= 1'b0;
                    cnt        <= '0;
                    fetch_addr <= '0;
                end else if (btn_play) begin
                    state <= PLAY;
                end
                DONE: if (btn_play || btn_restart) begin
                    state      <= PRIME;
                    auto_play  <= 1'b1;
                    fetch_addr <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: directed scenario bench for the music sequencer (SONG_LEN=6, BEAT_CYCLES=8)
module tb_music_sequencer;
    logic       EGO1_Clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_play = 1'b0;
    logic       btn_restart = 1'b0;
    logic [1:0] tempo_sel = 2'd0;
    logic       loop_en = 1'b0;
    logic [5:0] track0, track1, track2, track3;
    logic [5:0] note_pos;
    logic       playing, song_done, beat_pulse;
    logic [23:0] win;
    int checks = 0;
    int failures = 0;

    music_sequencer #(.SONG_LEN(6), .ADDR_W(6), .BEAT_CYCLES(8)) dut (
        .EGO1_Clock  (EGO1_Clock),
        .reset       (reset),
        .btn_play    (btn_play),
        .btn_restart (btn_restart),
        .tempo_sel   (tempo_sel),
        .loop_en     (loop_en),
        .track0      (track0),
        .track1      (track1),
        .track2      (track2),
        .track3      (track3),
        .note_pos    (note_pos),
        .playing     (playing),
        .song_done   (song_done),
        .beat_pulse  (beat_pulse)
    );

    assign win = {track0, track1, track2, track3};

    always #5 EGO1_Clock = ~EGO1_Clock;

    task automatic step(input int n);
        repeat (n) @(negedge EGO1_Clock);
    endtask

    task automatic press(input logic p, input logic r);
        btn_play = p;
        btn_restart = r;
        @(negedge EGO1_Clock);
        btn_play = 1'b0;
        btn_restart = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic start_play();
        press(1'b1, 1'b0);
        step(5);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (win !== 24'h0) begin failures++; $display("FAIL reset_tracks got %h exp %h", win, 24'h0); end
        checks++; if ({note_pos, playing, song_done, beat_pulse} !== 9'h0) begin failures++; $display("FAIL reset_flags got %h exp %h", {note_pos, playing, song_done, beat_pulse}, 9'h0); end
    endtask

    task automatic test_start();
        do_reset();
        press(1'b1, 1'b0);
        step(4);
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL prime_len got %b exp %b", playing, 1'b0); end
        step(1);
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL play_reached got %b exp %b", playing, 1'b1); end
        checks++; if (win !== {6'd1, 6'd2, 6'd3, 6'd4}) begin failures++; $display("FAIL start_window got %h exp %h", win, {6'd1, 6'd2, 6'd3, 6'd4}); end
        checks++; if (note_pos !== 6'd0) begin failures++; $display("FAIL start_pos got %0d exp %0d", note_pos, 0); end
        step(7);
        checks++; if (beat_pulse !== 1'b0) begin failures++; $display("FAIL early_pulse got %b exp %b", beat_pulse, 1'b0); end
        step(1);
        checks++; if (beat_pulse !== 1'b1) begin failures++; $display("FAIL first_pulse got %b exp %b", beat_pulse, 1'b1); end
        checks++; if (win !== {6'd2, 6'd3, 6'd4, 6'd5}) begin failures++; $display("FAIL tick1_window got %h exp %h", win, {6'd2, 6'd3, 6'd4, 6'd5}); end
        checks++; if (note_pos !== 6'd1) begin failures++; $display("FAIL tick1_pos got %0d exp %0d", note_pos, 1); end
        step(1);
        checks++; if (beat_pulse !== 1'b0) begin failures++; $display("FAIL pulse_width got %b exp %b", beat_pulse, 1'b0); end
    endtask

    task automatic test_tail();
        do_reset();
        loop_en = 1'b0;
        start_play();
        step(8 * 4);
        checks++; if (win !== {6'd5, 6'd6, 6'd0, 6'd0}) begin failures++; $display("FAIL tail4_window got %h exp %h", win, {6'd5, 6'd6, 6'd0, 6'd0}); end
        step(8);
        checks++; if (win !== {6'd6, 6'd0, 6'd0, 6'd0}) begin failures++; $display("FAIL tail5_window got %h exp %h", win, {6'd6, 6'd0, 6'd0, 6'd0}); end
        checks++; if (note_pos !== 6'd5) begin failures++; $display("FAIL tail5_pos got %0d exp %0d", note_pos, 5); end
        step(7);
        checks++; if (song_done !== 1'b0) begin failures++; $display("FAIL early_done got %b exp %b", song_done, 1'b0); end
        step(1);
        checks++; if ({song_done, playing} !== 2'b10) begin failures++; $display("FAIL done_state got %b exp %b", {song_done, playing}, 2'b10); end
        checks++; if (win !== 24'h0) begin failures++; $display("FAIL done_window got %h exp %h", win, 24'h0); end
        step(20);
        checks++; if ({song_done, win} !== {1'b1, 24'h0}) begin failures++; $display("FAIL done_hold got %h exp %h", {song_done, win}, {1'b1, 24'h0}); end
        press(1'b0, 1'b1);
        step(5);
        checks++; if ({playing, song_done, win} !== {2'b10, 6'd1, 6'd2, 6'd3, 6'd4}) begin failures++; $display("FAIL done_restart got %h exp %h", {playing, song_done, win}, {2'b10, 6'd1, 6'd2, 6'd3, 6'd4}); end
    endtask

    task automatic test_loop();
        do_reset();
        loop_en = 1'b1;
        start_play();
        step(8 * 6);
        checks++; if ({playing, song_done} !== 2'b00) begin failures++; $display("FAIL loop_prime got %b exp %b", {playing, song_done}, 2'b00); end
        step(5);
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL loop_playing got %b exp %b", playing, 1'b1); end
        checks++; if ({win, note_pos} !== {6'd1, 6'd2, 6'd3, 6'd4, 6'd0}) begin failures++; $display("FAIL loop_window got %h exp %h", {win, note_pos}, {6'd1, 6'd2, 6'd3, 6'd4, 6'd0}); end
        loop_en = 1'b0;
    endtask

    task automatic test_pause();
        do_reset();
        start_play();
        step(3);
        press(1'b1, 1'b0);
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL pause_enter got %b exp %b", playing, 1'b0); end
        step(100);
        checks++; if ({win, note_pos, playing, beat_pulse} !== {6'd1, 6'd2, 6'd3, 6'd4, 6'd0, 2'b00}) begin failures++; $display("FAIL pause_hold got %h exp %h", {win, note_pos, playing, beat_pulse}, {6'd1, 6'd2, 6'd3, 6'd4, 6'd0, 2'b00}); end
        press(1'b1, 1'b0);
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL resume got %b exp %b", playing, 1'b1); end
        step(4);
        checks++; if (beat_pulse !== 1'b0) begin failures++; $display("FAIL resume_early got %b exp %b", beat_pulse, 1'b0); end
        step(1);
        checks++; if ({beat_pulse, win} !== {1'b1, 6'd2, 6'd3, 6'd4, 6'd5}) begin failures++; $display("FAIL resume_tick got %h exp %h", {beat_pulse, win}, {1'b1, 6'd2, 6'd3, 6'd4, 6'd5}); end
    endtask

    task automatic test_restart();
        do_reset();
        start_play();
        step(8);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        step(5);
        checks++; if ({playing, win, note_pos} !== {1'b0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd0}) begin failures++; $display("FAIL pause_restart got %h exp %h", {playing, win, note_pos}, {1'b0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd0}); end
        press(1'b1, 1'b0);
        step(8);
        checks++; if ({win, note_pos} !== {6'd2, 6'd3, 6'd4, 6'd5, 6'd1}) begin failures++; $display("FAIL restart_tick got %h exp %h", {win, note_pos}, {6'd2, 6'd3, 6'd4, 6'd5, 6'd1}); end
        step(2);
        press(1'b1, 1'b1);
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL both_prime got %b exp %b", playing, 1'b0); end
        step(5);
        checks++; if ({playing, win, note_pos} !== {1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd0}) begin failures++; $display("FAIL both_play got %h exp %h", {playing, win, note_pos}, {1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd0}); end
    endtask

    task automatic test_tempo();
        do_reset();
        start_play();
        step(3);
        tempo_sel = 2'd2;
        step(4);
        checks++; if (beat_pulse !== 1'b0) begin failures++; $display("FAIL tempo_short got %b exp %b", beat_pulse, 1'b0); end
        step(1);
        checks++; if ({beat_pulse, win} !== {1'b1, 6'd2, 6'd3, 6'd4, 6'd5}) begin failures++; $display("FAIL tempo_first got %h exp %h", {beat_pulse, win}, {1'b1, 6'd2, 6'd3, 6'd4, 6'd5}); end
        step(1);
        checks++; if (beat_pulse !== 1'b0) begin failures++; $display("FAIL tempo_gap got %b exp %b", beat_pulse, 1'b0); end
        step(1);
        checks++; if ({beat_pulse, win, note_pos} !== {1'b1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd2}) begin failures++; $display("FAIL tempo_fast got %h exp %h", {beat_pulse, win, note_pos}, {1'b1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd2}); end
        step(1);
        reset = 1'b1;
        step(1);
        checks++; if ({win, note_pos, playing, song_done, beat_pulse} !== 33'h0) begin failures++; $display("FAIL midbeat_reset got %h exp %h", {win, note_pos, playing, song_done, beat_pulse}, 33'h0); end
        reset = 1'b0;
        tempo_sel = 2'd3;
        start_play();
        step(15);
        checks++; if (beat_pulse !== 1'b0) begin failures++; $display("FAIL double_early got %b exp %b", beat_pulse, 1'b0); end
        step(1);
        checks++; if (beat_pulse !== 1'b1) begin failures++; $display("FAIL double_tick got %b exp %b", beat_pulse, 1'b1); end
        tempo_sel = 2'd0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_tail();
        test_loop();
        test_pause();
        test_restart();
        test_tempo();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
